decode_share_ctrl: RTL and testbench

// - Shares one 2:1-mux + 2-to-4 one-hot decode datapath between two requesters (A, B).
// - Arbitrates round-robin, drives datapath select/operands, waits a fixed settle time.
// - Captures the one-hot result and returns it to the granted requester with a done pulse.
// - Sits directly in front of the decode datapath; the datapath itself is untouched.

---
 rtl/decode_share_ctrl_pkg.sv | 18 +
 rtl/decode_share_ctrl_rr_arb2.sv | 42 ++++
 rtl/decode_share_ctrl.sv | 176 +++++++++++++++++
 tb/tb_decode_share_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_share_ctrl_pkg.sv
// Shared types and constants for the decode-share controller.
// Imported by the top and the round-robin arbiter.
package decode_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/decode_share_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
// Pointer names the side that wins a tie; it moves to the other side of the served one.
module decode_share_ctrl_rr_arb2
  import decode_share_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       served_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= SEL_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      ptr_d = ~served_i;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (ptr_q == SEL_B) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/decode_share_ctrl.sv
// Shares one mux+decode datapath between requesters A and B.
// Grants round-robin, waits a fixed settle time, returns the captured one-hot.
module decode_share_ctrl
  import decode_share_ctrl_pkg::*;
#(
  parameter int DATA_W        = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     a_req_i,
  input  logic [DATA_W-1:0]        a_data_i,
  output logic                     a_gnt_o,
  output logic                     a_done_o,
  output logic [(1<<DATA_W)-1:0]   a_result_o,
  input  logic                     b_req_i,
  input  logic [DATA_W-1:0]        b_data_i,
  output logic                     b_gnt_o,
  output logic                     b_done_o,
  output logic [(1<<DATA_W)-1:0]   b_result_o,
  output logic                     dp_sel_o,
  output logic [DATA_W-1:0]        dp_a_o,
  output logic [DATA_W-1:0]        dp_b_o,
  input  logic [(1<<DATA_W)-1:0]   dp_onehot_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int RES_W = 1 << DATA_W;
  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] dpa_q, dpa_d;
  logic [DATA_W-1:0] dpb_q, dpb_d;
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic [RES_W-1:0]  a_res_q, a_res_d;
  logic [RES_W-1:0]  b_res_q, b_res_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [1:0] arb_gnt;
  logic       any_req;
  logic       cnt_zero;

  assign any_req  = a_req_i | b_req_i;
  assign cnt_zero = (cnt_q == '0);

  // Pointer advances only once the served transaction retires.
  decode_share_ctrl_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({b_req_i, a_req_i}),
    .upd_i    (state_q == ST_DONE),
    .served_i (sel_q),
    .gnt_o    (arb_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req)  state_d = ST_WAIT;
      ST_WAIT: if (cnt_zero) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    dpa_d    = dpa_q;
    dpb_d    = dpb_q;
    a_gnt_d  = 1'b0;
    b_gnt_d  = 1'b0;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    a_res_d  = a_res_q;
    b_res_d  = b_res_q;
    err_d    = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          cnt_d = CNT_INIT;
          if (arb_gnt[1]) begin
            sel_d   = SEL_B;
            dpb_d   = b_data_i;
            b_gnt_d = 1'b1;
          end else begin
            sel_d   = SEL_A;
            dpa_d   = a_data_i;
            a_gnt_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          err_d = ($countones(dp_onehot_i) != 1);
          if (sel_q == SEL_B) begin
            b_res_d  = dp_onehot_i;
            b_done_d = 1'b1;
          end else begin
            a_res_d  = dp_onehot_i;
            a_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sel_q    <= SEL_A;
      dpa_q    <= '0;
      dpb_q    <= '0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      a_res_q  <= '0;
      b_res_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      dpa_q    <= dpa_d;
      dpb_q    <= dpb_d;
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      a_res_q  <= a_res_d;
      b_res_q  <= b_res_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign a_gnt_o    = a_gnt_q;
  assign b_gnt_o    = b_gnt_q;
  assign a_done_o   = a_done_q;
  assign b_done_o   = b_done_q;
  assign a_result_o = a_res_q;
  assign b_result_o = b_res_q;
  assign dp_sel_o   = sel_q;
  assign dp_a_o     = dpa_q;
  assign dp_b_o     = dpb_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_decode_share_ctrl.sv
// Bench for decode_share_ctrl: vector table plus scoreboard of expected results.
// Hand sequences cover arbitration order, busy-time requests and mid-transaction reset.
module tb_decode_share_ctrl;

  localparam int SETTLE = 3;

  typedef struct {
    logic       who;
    logic [1:0] data;
    logic       frc;
    logic [3:0] fval;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic       who;
    logic [3:0] res;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0;
  logic [1:0] a_data = 2'b00;
  logic       b_req = 1'b0;
  logic [1:0] b_data = 2'b00;
  logic       a_gnt, a_done, b_gnt, b_done;
  logic [3:0] a_result, b_result;
  logic       dp_sel, busy, err;
  logic [1:0] dp_a, dp_b;
  logic [3:0] dp_onehot;
  logic       frc = 1'b0;
  logic [3:0] fval = 4'b0000;

  exp_t sb[$];
  vec_t vt[7];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int a_gnt_cyc = 0;
  int b_gnt_cyc = 0;
  int k;
  int a_gnts;
  int done_at;
  int gnt_at;
  logic [3:0] other;
  logic quiet;

  always #5 clk = ~clk;

  // External datapath: mux the selected operand, then 2-to-4 decode.
  assign dp_onehot = frc ? fval : (4'b0001 << (dp_sel ? dp_b : dp_a));

  decode_share_ctrl #(
    .DATA_W        (2),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .a_req_i     (a_req),
    .a_data_i    (a_data),
    .a_gnt_o     (a_gnt),
    .a_done_o    (a_done),
    .a_result_o  (a_result),
    .b_req_i     (b_req),
    .b_data_i    (b_data),
    .b_gnt_o     (b_gnt),
    .b_done_o    (b_done),
    .b_result_o  (b_result),
    .dp_sel_o    (dp_sel),
    .dp_a_o      (dp_a),
    .dp_b_o      (dp_b),
    .dp_onehot_i (dp_onehot),
    .busy_o      (busy),
    .err_o       (err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      if (a_gnt) begin
        a_gnt_cyc = cyc;
        chk("busy_at_a_gnt", 32'(busy), 32'd1);
        chk("a_gnt_sel", 32'(dp_sel), 32'd0);
        chk("a_gnt_operand", 32'(dp_a), 32'(a_data));
      end
      if (b_gnt) begin
        b_gnt_cyc = cyc;
        chk("busy_at_b_gnt", 32'(busy), 32'd1);
        chk("b_gnt_sel", 32'(dp_sel), 32'd1);
        chk("b_gnt_operand", 32'(dp_b), 32'(b_data));
      end
      if (a_done || b_done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_side", 32'(b_done), 32'(e.who));
          chk("single_done", 32'(a_done & b_done), 32'd0);
          chk("result", 32'(e.who ? b_result : a_result), 32'(e.res));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", 32'(cyc - (e.who ? b_gnt_cyc : a_gnt_cyc)),
              32'(SETTLE));
        end
      end else if (err) begin
        chk("err_without_done", 32'(err), 32'd0);
      end
    end
  end

  task automatic wait_gnt(input logic who, input string nm);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (who ? b_gnt : a_gnt) break;
    end
    chk(nm, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_done(input logic who, input string nm);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (who ? b_done : a_done) break;
    end
    chk(nm, 32'(n < 20), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input logic who, input logic [1:0] d,
                            input logic [3:0] res, input logic e);
    sb.push_back('{who, res, e});
    step();
    if (who) begin
      b_req = 1'b1;
      b_data = d;
    end else begin
      a_req = 1'b1;
      a_data = d;
    end
    wait_gnt(who, "gnt_timeout");
    step();
    a_req = 1'b0;
    b_req = 1'b0;
    wait_done(who, "done_timeout");
    step();
  endtask

  initial begin
    vt[0] = '{1'b0, 2'b10, 1'b0, 4'h0, 4'b0100, 1'b0};
    vt[1] = '{1'b1, 2'b01, 1'b0, 4'h0, 4'b0010, 1'b0};
    vt[2] = '{1'b0, 2'b00, 1'b0, 4'h0, 4'b0001, 1'b0};
    vt[3] = '{1'b1, 2'b11, 1'b0, 4'h0, 4'b1000, 1'b0};
    vt[4] = '{1'b0, 2'b01, 1'b1, 4'b0110, 4'b0110, 1'b1};
    vt[5] = '{1'b1, 2'b10, 1'b1, 4'b0000, 4'b0000, 1'b1};
    vt[6] = '{1'b0, 2'b11, 1'b0, 4'h0, 4'b1000, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs",
        32'({a_gnt, a_done, a_result, b_gnt, b_done, b_result,
             dp_sel, dp_a, dp_b, busy, err}), 32'd0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      other = vt[i].who ? a_result : b_result;
      frc = vt[i].frc;
      fval = vt[i].fval;
      run_single(vt[i].who, vt[i].data, vt[i].exp_res, vt[i].exp_err);
      chk("other_result_kept",
          32'(vt[i].who ? a_result : b_result), 32'(other));
      frc = 1'b0;
      step();
    end

    // Both requesting from reset: grants must alternate A,B,A,B.
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_req = 1'b1;
    a_data = 2'b00;
    b_req = 1'b1;
    b_data = 2'b11;
    sb.push_back('{1'b0, 4'b0001, 1'b0});
    sb.push_back('{1'b1, 4'b1000, 1'b0});
    sb.push_back('{1'b0, 4'b0001, 1'b0});
    sb.push_back('{1'b1, 4'b1000, 1'b0});
    for (int j = 0; j < 4; j++) begin
      wait_done(j[0], "alt_done_timeout");
    end
    step();
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (3) step();
    chk("alt_all_popped", 32'(sb.size()), 32'd0);

    // Requests while busy: A pulse ignored, B waits for DONE->IDLE.
    sb.push_back('{1'b0, 4'b0100, 1'b0});
    step();
    a_req = 1'b1;
    a_data = 2'b10;
    wait_gnt(1'b0, "busy_a_gnt_timeout");
    step();
    a_req = 1'b0;
    step();
    a_req = 1'b1;
    a_data = 2'b01;
    b_req = 1'b1;
    b_data = 2'b01;
    sb.push_back('{1'b1, 4'b0010, 1'b0});
    step();
    a_req = 1'b0;
    a_gnts = 0;
    done_at = -1;
    gnt_at = -1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_gnt) a_gnts++;
      if (a_done) done_at = k;
      if (b_gnt) begin
        gnt_at = k;
        break;
      end
    end
    chk("busy_no_extra_a_gnt", 32'(a_gnts), 32'd0);
    chk("b_gnt_after_done", 32'(gnt_at - done_at), 32'd2);
    step();
    b_req = 1'b0;
    wait_done(1'b1, "busy_b_done_timeout");
    step();

    // Leave pointer at B, then abandon an A transaction by reset.
    run_single(1'b0, 2'b10, 4'b0100, 1'b0);
    step();
    a_req = 1'b1;
    a_data = 2'b01;
    wait_gnt(1'b0, "abandon_gnt_timeout");
    step();
    a_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midwait_reset_outputs",
        32'({a_gnt, a_done, a_result, b_gnt, b_done, b_result,
             dp_sel, dp_a, dp_b, busy, err}), 32'd0);
    quiet = 1'b0;
    repeat (5) begin
      @(negedge clk);
      quiet = quiet | a_done | b_done | err | busy;
    end
    chk("abandoned_no_done", 32'(quiet), 32'd0);
    sb.push_back('{1'b0, 4'b0010, 1'b0});
    step();
    a_req = 1'b1;
    a_data = 2'b01;
    b_req = 1'b1;
    b_data = 2'b10;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a_gnt || b_gnt) break;
    end
    chk("ptr_reset_a_wins", 32'(a_gnt), 32'd1);
    step();
    a_req = 1'b0;
    b_req = 1'b0;
    wait_done(1'b0, "post_reset_done_timeout");
    repeat (3) step();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
